// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-channel cache-line arbiter onto a single burst memory port
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (channel 0 highest) otherwise.

module mem_arbiter_n #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_read_i,
  input  logic [NUM_CH-1:0]          ch_write_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wline_i,
  output logic [LINE_W-1:0]          ch_rline_o,
  output logic [NUM_CH-1:0]          ch_resp_o,
  output logic                       stall_o,
  input  logic                       resp_i,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  output logic [ADDR_W-1:0]          address_o,
  output logic                       read_o,
  output logic                       write_o
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     grant_q, grant_sel;
  logic [LINE_W-1:0]   line_q, line_rd;
  logic [NUM_CH-1:0]   req, grant_oh;
  logic [ADDR_W-1:0]   addr_sel;
  logic [LINE_W-1:0]   wline_sel;
  logic                last_beat;

  assign req       = ch_read_i | ch_write_i;
  assign grant_oh  = NUM_CH'(1) << grant_q;
  assign addr_sel  = ch_addr_i[int'(grant_sel)*ADDR_W +: ADDR_W];
  assign wline_sel = ch_wline_i[int'(grant_sel)*LINE_W +: LINE_W];
  assign last_beat = resp_i && (cnt_q == CNT_LAST);
  assign burst_o   = line_q[int'(cnt_q)*BURST_W +: BURST_W];
  assign stall_o   = (|req) & (state_q != ST_DONE);

  // Incoming beat merged into the partially assembled line, LSB beat first.
  always_comb begin
    line_rd = line_q;
    line_rd[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr_q;
  int              cand;

  // Walk downwards so the candidate closest to the pointer is assigned last and wins.
  always_comb begin
    grant_sel = '0;
    cand      = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (req[cand[CH_W-1:0]]) grant_sel = cand[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == ST_DONE) begin
      rr_ptr_q <= (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
    end
  end
`else
  always_comb begin
    grant_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) grant_sel = CH_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ch_write_i[grant_sel] ? ST_WRITE : ST_READ;
      ST_READ:  if (last_beat) state_d = ST_DONE;
      ST_WRITE: if (last_beat) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      grant_q    <= '0;
      line_q     <= '0;
      address_o  <= '0;
      ch_rline_o <= '0;
      ch_resp_o  <= '0;
      read_o     <= 1'b0;
      write_o    <= 1'b0;
    end else begin
      read_o    <= (state_d == ST_READ);
      write_o   <= (state_d == ST_WRITE);
      ch_resp_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q   <= grant_sel;
            address_o <= addr_sel & ADDR_MASK;
            line_q    <= wline_sel;
            cnt_q     <= '0;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            line_q <= line_rd;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              ch_rline_o <= line_rd;
              ch_resp_o  <= grant_oh;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              ch_rline_o <= line_q;
              ch_resp_o  <= grant_oh;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - randomized scoreboard bench for mem_arbiter_n
// Honours MEM_ARB_ROUND_ROBIN_EN (4 channels, round-robin model) when defined.

module tb_mem_arbiter_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int BEATS = LW / BW;

  logic              clk;
  logic              reset_n;
  logic [NCH-1:0]    ch_read_i, ch_write_i;
  logic [NCH*AW-1:0] ch_addr_i;
  logic [NCH*LW-1:0] ch_wline_i;
  logic [LW-1:0]     ch_rline_o;
  logic [NCH-1:0]    ch_resp_o;
  logic              stall_o;
  logic              resp_i;
  logic [BW-1:0]     burst_i, burst_o;
  logic [AW-1:0]     address_o;
  logic              read_o, write_o;

  mem_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .BURST_W(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_read_i(ch_read_i), .ch_write_i(ch_write_i),
    .ch_addr_i(ch_addr_i), .ch_wline_i(ch_wline_i),
    .ch_rline_o(ch_rline_o), .ch_resp_o(ch_resp_o), .stall_o(stall_o),
    .resp_i(resp_i), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } exp_t;

  exp_t exp_q[NCH][$];
  exp_t cur;

  int n_cmp = 0;
  int n_fail = 0;
  int resp_count[NCH];
  int handled[NCH];
  int cool[NCH];
  bit active[NCH];
  int resp_mode = 0;
  bit rand_en = 0;

  bit busy = 0;
  bit pend = 0;
  int acks = 0;
  int cur_ch = 0;
  int model_ptr = 0;
  logic [NCH-1:0] req_prev = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents are a pure function of the line address and beat number.
  function automatic logic [BW-1:0] mem_beat(input logic [AW-1:0] a, input int b);
    return {a ^ 32'hC0DE_0000, 32'(b + 1) * 32'h1111_1111};
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*BW +: BW] = mem_beat(a, b);
    return l;
  endfunction

  function automatic int pick(input logic [NCH-1:0] r, input int ptr);
    int c;
    for (int i = 0; i < NCH; i++) begin
      c = (ptr + i) % NCH;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Memory side: acknowledges per resp_mode, returns beats in order per transaction.
  initial begin
    bit prev_act, prev_ack, act;
    int mem_cnt;
    prev_act = 0; prev_ack = 0; mem_cnt = 0;
    resp_i = 1'b0; burst_i = '0;
    forever begin
      @(posedge clk); #1;
      act = read_o | write_o;
      if (act && !prev_act) mem_cnt = 0;
      else if (prev_ack) mem_cnt++;
      prev_act = act;
      case (resp_mode)
        0: resp_i = 1'b1;
        1: resp_i = ~resp_i;
        default: resp_i = ($urandom_range(0, 3) != 0);
      endcase
      burst_i = read_o ? mem_beat(address_o, mem_cnt % BEATS) : {$urandom, $urandom};
      prev_ack = act && resp_i;
    end
  end

  // Monitor: infers grants from the reference policy and pops the scoreboard on each response.
  always @(negedge clk) begin
    logic [NCH-1:0] req_now;
    int g;
    req_now = ch_read_i | ch_write_i;
    if (!reset_n) begin
      busy = 0; pend = 0; model_ptr = 0;
    end else if (busy && acks == BEATS) begin
      check("resp_onehot", LW'(ch_resp_o), LW'(1) << cur_ch);
      check("rline", ch_rline_o, cur.line);
      check("done_rw_low", LW'({read_o, write_o}), '0);
      check("stall_done", LW'(stall_o), '0);
      void'(exp_q[cur_ch].pop_front());
      resp_count[cur_ch]++;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      model_ptr = (cur_ch + 1) % NCH;
`endif
      busy = 0;
    end else begin
      if (!busy) begin
        check("stall_idle", LW'(stall_o), LW'(|req_now));
        if (read_o || write_o) begin
          g = pick(req_prev, model_ptr);
          check("start_has_req", LW'(g >= 0 && exp_q[g >= 0 ? g : 0].size() > 0), LW'(1));
          if (g >= 0 && exp_q[g].size() > 0) begin
            cur = exp_q[g][0];
            cur_ch = g;
            check("address", LW'(address_o), LW'(cur.addr & ~32'h1F));
            busy = 1; acks = 0;
          end
          pend = 0;
        end else begin
          if (pend) check("grant_timing", LW'(read_o | write_o), LW'(1));
          check("resp_idle", LW'(ch_resp_o), '0);
          pend = |req_now;
        end
      end else begin
        check("stall_busy", LW'(stall_o), LW'(|req_now));
      end
      if (busy) begin
        check("resp_quiet", LW'(ch_resp_o), '0);
        check("op_level", LW'({read_o, write_o}), cur.wr ? LW'(2'b01) : LW'(2'b10));
        if (resp_i) begin
          if (cur.wr) check("wbeat", LW'(burst_o), LW'(cur.line[acks*BW +: BW]));
          acks++;
        end
      end
    end
    req_prev = req_now;
  end

  task automatic issue(input int ch, input int op, input logic [AW-1:0] a, input logic [LW-1:0] wl);
    exp_t e;
    e.wr = (op != 0);
    e.addr = a;
    e.line = e.wr ? wl : mem_line(a & ~32'h1F);
    exp_q[ch].push_back(e);
    ch_read_i[ch]  = (op != 1);
    ch_write_i[ch] = (op != 0);
    ch_addr_i[ch*AW +: AW] = a;
    ch_wline_i[ch*LW +: LW] = wl;
    active[ch] = 1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic step();
    int r;
    @(posedge clk); #1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (active[ch] && resp_count[ch] != handled[ch]) begin
        handled[ch]++;
        ch_read_i[ch] = 1'b0; ch_write_i[ch] = 1'b0;
        active[ch] = 0;
        cool[ch] = $urandom_range(1, 4);
      end else if (!active[ch] && cool[ch] > 0) begin
        cool[ch]--;
      end
    end
    if (rand_en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (!active[ch] && cool[ch] == 0 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 19);
          issue(ch, (r < 9) ? 0 : (r < 18) ? 1 : 2, $urandom, rand_line());
        end
      end
    end
  endtask

  task automatic wait_done(input int bound);
    bit any;
    for (int i = 0; i < bound; i++) begin
      step();
      any = 0;
      for (int ch = 0; ch < NCH; ch++) any |= active[ch];
      if (!any) return;
    end
    check("drain_timeout", LW'(1), LW'(0));
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    ch_read_i = '0; ch_write_i = '0; ch_addr_i = '0; ch_wline_i = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      resp_count[ch] = 0; handled[ch] = 0; cool[ch] = 0; active[ch] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_read", LW'(read_o), '0);
    check("rst_write", LW'(write_o), '0);
    check("rst_resp", LW'(ch_resp_o), '0);
    check("rst_burst", LW'(burst_o), '0);
    check("rst_addr", LW'(address_o), '0);
    check("rst_rline", ch_rline_o, '0);
    check("rst_stall", LW'(stall_o), '0);
    #2 reset_n = 1'b1;

    // Single read, continuous acknowledge: response in cycle BEATS+1 after the grant edge.
    resp_mode = 0;
    step();
    issue(0, 0, 32'h0000_1234, '0);
    n = 0;
    while (active[0] && n < 40) begin step(); n++; end
    check("read_latency", LW'(n), LW'(BEATS + 2));
    wait_done(20);

    issue(NCH - 1, 1, 32'h0000_8040, {{(LW/4 - 1){4'hA}}, 4'h1});
    wait_done(40);

    issue(0, 0, 32'h0000_2000, '0);
    issue(1, 0, 32'h0000_3000, '0);
    wait_done(60);

    resp_mode = 1;
    issue(1, 0, 32'h0000_4567, '0);
    wait_done(60);

    // Abort mid-burst; the held request must complete from beat 0 afterwards.
    resp_mode = 0;
    issue(0, 0, 32'h0000_5000, '0);
    n = 0;
    while (!(busy && acks >= 2) && n < 40) begin step(); n++; end
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check("abort_read", LW'(read_o), '0);
    check("abort_write", LW'(write_o), '0);
    check("abort_resp", LW'(ch_resp_o), '0);
    check("abort_burst", LW'(burst_o), '0);
    check("abort_addr", LW'(address_o), '0);
    check("abort_rline", ch_rline_o, '0);
    @(negedge clk); #2 reset_n = 1'b1;
    wait_done(60);

    rand_en = 1;
    for (int blk = 0; blk < 15; blk++) begin
      resp_mode = $urandom_range(0, 2);
      repeat (200) step();
    end
    rand_en = 0;
    resp_mode = 2;
    wait_done(1000);

    for (int ch = 0; ch < NCH; ch++) check("queue_empty", LW'(exp_q[ch].size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
